// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared main-memory port between I-cache fills, D-cache fills
// and D-side write-through stores, sequencing block fills word by word.
module mem_fill_arbiter #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic [15:0]       fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic              i_data_we,
  output logic              d_data_we,
  output logic              i_tag_we,
  output logic              d_tag_we,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  localparam int IDX_W  = $clog2(WORDS);
  localparam int BASE_W = ADDR_W - IDX_W - 1;
  localparam logic [IDX_W:0]   WORDS_C  = (IDX_W+1)'(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [IDX_W:0]      iss_q, iss_d;
  logic [IDX_W-1:0]    rcv_q, rcv_d;

  // Byte offset bits below the block base are not needed to address a fill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_miss_addr[IDX_W:0], d_miss_addr[IDX_W:0]};

  assign fill_data = mem_rdata;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      iss_q   <= '0;
      rcv_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      iss_q   <= iss_d;
      rcv_q   <= rcv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    iss_d       = iss_q;
    rcv_d       = rcv_q;
    d_wr_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_word   = '0;
    i_data_we   = 1'b0;
    d_data_we   = 1'b0;
    i_tag_we    = 1'b0;
    d_tag_we    = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stores first so write-through data never sits behind a whole fill.
        if (d_wr_req) begin
          state_d = WRITE;
        end else if (d_miss_req) begin
          state_d = FILL_D;
          base_d  = d_miss_addr[ADDR_W-1 -: BASE_W];
          iss_d   = '0;
          rcv_d   = '0;
        end else if (i_miss_req) begin
          state_d = FILL_I;
          base_d  = i_miss_addr[ADDR_W-1 -: BASE_W];
          iss_d   = '0;
          rcv_d   = '0;
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
        state_d   = IDLE;
      end

      FILL_I, FILL_D: begin
        // Issue runs ahead of returns; the word index never carries into the base.
        if (iss_q < WORDS_C) begin
          mem_en   = 1'b1;
          mem_addr = {base_q, iss_q[IDX_W-1:0], 1'b0};
          iss_d    = iss_q + (IDX_W+1)'(1);
        end
        fill_word = rcv_q;
        if (mem_rvalid) begin
          i_data_we = (state_q == FILL_I);
          d_data_we = (state_q == FILL_D);
          rcv_d     = rcv_q + IDX_W'(1);
          if (rcv_q == LAST_IDX) begin
            i_tag_we    = (state_q == FILL_I);
            d_tag_we    = (state_q == FILL_D);
            i_fill_done = (state_q == FILL_I);
            d_fill_done = (state_q == FILL_D);
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model.
module tb_mem_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [2:0]  fill_word;
  logic        i_data_we, d_data_we, i_tag_we, d_tag_we, i_fill_done, d_fill_done, busy;

  mem_fill_arbiter #(.ADDR_W(16), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_we(i_data_we), .d_data_we(d_data_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: a read issued in cycle c returns in cycle c+lat with data addr^0x5A5A.
  int          lat = 4;
  logic        stray = 1'b0;
  logic        pv [16];
  logic [15:0] pa [16];
  initial for (int i = 0; i < 16; i++) begin pv[i] = 1'b0; pa[i] = '0; end
  always @(posedge clk) begin
    for (int i = 15; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
  end
  assign mem_rvalid = pv[lat-1] | stray;
  assign mem_rdata  = stray ? 16'h0000 : (pa[lat-1] ^ 16'h5A5A);

  // Event log sampled on the falling edge.
  logic [15:0] rd_addr [$];
  int          rd_cyc  [$];
  int          iw_word [$];
  logic [15:0] iw_data [$];
  int          dw_word [$];
  logic [15:0] dw_data [$];
  int i_tag_cnt = 0, i_done_cnt = 0, d_tag_cnt = 0, d_done_cnt = 0;
  int i_tag_cyc = 0, i_done_cyc = 0, d_tag_cyc = 0, d_done_cyc = 0;
  int wr_cnt = 0, ack_cnt = 0, ack_cyc = 0;
  logic [15:0] ack_addr = '0, ack_wdata = '0;
  logic        ack_wr = 1'b0;

  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(cyc); end
    if (mem_en && mem_wr) wr_cnt <= wr_cnt + 1;
    if (i_data_we) begin iw_word.push_back(int'(fill_word)); iw_data.push_back(fill_data); end
    if (d_data_we) begin dw_word.push_back(int'(fill_word)); dw_data.push_back(fill_data); end
    if (i_tag_we)    begin i_tag_cnt  <= i_tag_cnt + 1;  i_tag_cyc  <= cyc; end
    if (i_fill_done) begin i_done_cnt <= i_done_cnt + 1; i_done_cyc <= cyc; end
    if (d_tag_we)    begin d_tag_cnt  <= d_tag_cnt + 1;  d_tag_cyc  <= cyc; end
    if (d_fill_done) begin d_done_cnt <= d_done_cnt + 1; d_done_cyc <= cyc; end
    if (d_wr_ack) begin
      ack_cnt <= ack_cnt + 1; ack_cyc <= cyc;
      ack_addr <= mem_addr; ack_wdata <= mem_wdata; ack_wr <= mem_wr;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur(input int sel);
    case (sel)
      0:       return i_done_cnt;
      1:       return d_done_cnt;
      2:       return ack_cnt;
      default: return iw_word.size();
    endcase
  endfunction

  task automatic wait_ev(input string tag, input int sel, input int target);
    int seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (cur(sel) >= target) begin seen = 1; break; end
      tick();
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic check_fill(input string tag, input bit is_i, input int rb, input int wb,
                            input logic [15:0] base, input int t0);
    logic [15:0] a;
    check_eq({tag, "_nrd"}, (rd_addr.size() >= rb + 8), 1);
    check_eq({tag, "_nwe"}, ((is_i ? iw_word.size() : dw_word.size()) >= wb + 8), 1);
    for (int k = 0; k < 8; k++) begin
      a = base + 16'(2 * k);
      check_eq({tag, "_addr"}, rd_addr[rb+k], a);
      check_eq({tag, "_icyc"}, rd_cyc[rb+k], t0 + k);
      check_eq({tag, "_word"}, is_i ? iw_word[wb+k] : dw_word[wb+k], k);
      check_eq({tag, "_data"}, is_i ? iw_data[wb+k] : dw_data[wb+k], a ^ 16'h5A5A);
    end
  endtask

  int t0, t1, rb, wb, wb2, db, id0, it0, dd0, dt0, ak0, wc0;

  initial begin
    rst_n = 1'b0;
    i_miss_req = 0; d_miss_req = 0; d_wr_req = 0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    tick(); tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    check_eq("rst_mem_wdata", mem_wdata, 16'h0000);
    check_eq("rst_strobes", {d_wr_ack, i_data_we, d_data_we, i_tag_we, d_tag_we, i_fill_done, d_fill_done}, 0);
    check_eq("rst_fill_word", fill_word, 0);
    rst_n = 1'b1;
    tick();

    // I-miss alone, L=4
    lat = 4;
    rb = rd_addr.size(); wb = iw_word.size(); db = dw_word.size(); it0 = i_tag_cnt; id0 = i_done_cnt;
    i_miss_addr = 16'h1236; i_miss_req = 1; t0 = cyc + 1;
    wait_ev("s1_wait", 0, id0 + 1);
    i_miss_req = 0;
    check_eq("s1_idle_cyc", cyc, t0 + 12);
    check_eq("s1_busy_low", busy, 0);
    check_fill("s1", 1'b1, rb, wb, 16'h1230, t0);
    check_eq("s1_nreads", rd_addr.size() - rb, 8);
    check_eq("s1_tag_cyc", i_tag_cyc, t0 + 11);
    check_eq("s1_done_cyc", i_done_cyc, t0 + 11);
    check_eq("s1_tag_cnt", i_tag_cnt - it0, 1);
    check_eq("s1_no_dwe", dw_word.size() - db, 0);

    // D-miss, L=6
    tick();
    lat = 6;
    rb = rd_addr.size(); db = dw_word.size(); wb = iw_word.size(); it0 = i_tag_cnt; id0 = i_done_cnt; dd0 = d_done_cnt;
    d_miss_addr = 16'h4000; d_miss_req = 1; t0 = cyc + 1;
    wait_ev("s2_wait", 1, dd0 + 1);
    d_miss_req = 0;
    check_eq("s2_done_cyc", d_done_cyc, t0 + 13);
    check_eq("s2_tag_cyc", d_tag_cyc, t0 + 13);
    check_fill("s2", 1'b0, rb, db, 16'h4000, t0);
    check_eq("s2_no_iwe", iw_word.size() - wb, 0);
    check_eq("s2_no_itag", i_tag_cnt - it0, 0);
    check_eq("s2_no_idone", i_done_cnt - id0, 0);

    // Simultaneous I and D miss
    tick(); tick();
    lat = 4;
    rb = rd_addr.size(); db = dw_word.size(); wb = iw_word.size(); id0 = i_done_cnt; dd0 = d_done_cnt;
    d_miss_addr = 16'h3000; i_miss_addr = 16'h1000;
    d_miss_req = 1; i_miss_req = 1; t0 = cyc + 1;
    wait_ev("s3_wait_d", 1, dd0 + 1);
    d_miss_req = 0;
    check_eq("s3_d_done_cyc", d_done_cyc, t0 + 11);
    wait_ev("s3_wait_i", 0, id0 + 1);
    i_miss_req = 0;
    t1 = d_done_cyc + 2;
    check_fill("s3_d", 1'b0, rb, db, 16'h3000, t0);
    check_fill("s3_i", 1'b1, rb + 8, wb, 16'h1000, t1);
    check_eq("s3_i_done_cyc", i_done_cyc, t1 + 11);
    check_eq("s3_d_done_n", d_done_cnt - dd0, 1);
    check_eq("s3_i_done_n", i_done_cnt - id0, 1);

    // Store and D miss raised during an I fill
    tick();
    rb = rd_addr.size(); id0 = i_done_cnt; dd0 = d_done_cnt; ak0 = ack_cnt; wc0 = wr_cnt;
    i_miss_addr = 16'h0500; i_miss_req = 1; t0 = cyc + 1;
    tick(); tick(); tick();
    d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF; d_wr_req = 1;
    d_miss_addr = 16'h3000; d_miss_req = 1;
    wait_ev("s4_wait_i", 0, id0 + 1);
    i_miss_req = 0;
    check_eq("s4_store_waited", ack_cnt - ak0, 0);
    wait_ev("s4_wait_ack", 2, ak0 + 1);
    d_wr_req = 0;
    check_eq("s4_ack_cyc", ack_cyc, i_done_cyc + 2);
    check_eq("s4_ack_wr", ack_wr, 1);
    check_eq("s4_ack_addr", ack_addr, 16'h2002);
    check_eq("s4_ack_wdata", ack_wdata, 16'hBEEF);
    check_eq("s4_wr_cnt", wr_cnt - wc0, 1);
    check_eq("s4_ack_n", ack_cnt - ak0, 1);
    wait_ev("s4_wait_d", 1, dd0 + 1);
    d_miss_req = 0;
    check_eq("s4_d_first_addr", rd_addr[rb+8], 16'h3000);
    check_eq("s4_d_first_cyc", rd_cyc[rb+8], ack_cyc + 2);
    check_eq("s4_d_done_n", d_done_cnt - dd0, 1);

    // Reset mid-fill, stray returns, then a clean refill
    tick();
    wb = iw_word.size(); it0 = i_tag_cnt; id0 = i_done_cnt;
    i_miss_addr = 16'h1236; i_miss_req = 1;
    wait_ev("s5_wait_3", 3, wb + 3);
    rst_n = 1'b0;
    #1;
    check_eq("s5_rst_busy", busy, 0);
    check_eq("s5_rst_mem_en", mem_en, 0);
    check_eq("s5_rst_mem_addr", mem_addr, 16'h0000);
    check_eq("s5_rst_strobes", {i_data_we, i_tag_we, i_fill_done, d_data_we}, 0);
    check_eq("s5_rst_fill_word", fill_word, 0);
    i_miss_req = 0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    stray = 1'b1;
    tick(); tick();
    stray = 1'b0;
    tick();
    check_eq("s5_partial_we", iw_word.size() - wb, 3);
    check_eq("s5_no_tag", i_tag_cnt - it0, 0);
    check_eq("s5_no_done", i_done_cnt - id0, 0);
    check_eq("s5_idle", busy, 0);
    rb = rd_addr.size(); wb2 = iw_word.size();
    i_miss_req = 1; t0 = cyc + 1;
    wait_ev("s5_wait_refill", 0, id0 + 1);
    i_miss_req = 0;
    check_fill("s5_refill", 1'b1, rb, wb2, 16'h1230, t0);
    check_eq("s5_refill_tag", i_tag_cnt - it0, 1);

    // Wrap boundary
    tick();
    rb = rd_addr.size(); wb = iw_word.size(); id0 = i_done_cnt;
    i_miss_addr = 16'hFFFE; i_miss_req = 1; t0 = cyc + 1;
    wait_ev("s6_wait", 0, id0 + 1);
    i_miss_req = 0;
    check_fill("s6", 1'b1, rb, wb, 16'hFFF0, t0);
    check_eq("s6_nreads", rd_addr.size() - rb, 8);
    check_eq("s6_done_cyc", i_done_cyc, t0 + 11);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
# mem_fill_arbiter

- Shares the single main-memory port between the I-cache, D-cache and D-side write-through stores.
- On a cache miss it sequences an 8-word block fill: it issues word reads, counts the returns, and drives the cache data and tag write strobes.
- Sits between the two caches and the multi-cycle main memory inside the memory subsystem.
- Generates the `i_cache_miss` / `d_cache_miss` stall window seen by the pipeline.

## Interface
- `ADDR_W`, 16, byte address width
- `WORDS`, 8, 16-bit words per cache block (power of 2)
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_miss_req` in 1: I-cache miss. Level signal, held until `i_fill_done`.
- `i_miss_addr` in 16: I-cache miss byte address.
- `d_miss_req` in 1: D-cache miss. Level signal, held until `d_fill_done`.
- `d_miss_addr` in 16: D-cache miss byte address.
- `d_wr_req` in 1: write-through store request. Level signal, held until `d_wr_ack`.
- `d_wr_addr` in 16: store byte address.
- `d_wr_data` in 16: store data.
- `d_wr_ack` out 1: one-cycle pulse; the store was issued to memory.
- `mem_en` out 1: memory access strobe.
- `mem_wr` out 1: memory write (1) / read (0).
- `mem_addr` out 16: memory byte address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.
- `fill_data` out 16: word written into the cache (combinational copy of `mem_rdata`).
- `fill_word` out 3: word index within the block, equal to the receive count.
- `i_data_we` out 1: I-cache data-array write enable.
- `d_data_we` out 1: D-cache data-array write enable.
- `i_tag_we` out 1: I-cache tag/valid write, asserted on the last word.
- `d_tag_we` out 1: D-cache tag/valid write, asserted on the last word.
- `i_fill_done` out 1: one-cycle pulse; I-cache fill complete.
- `d_fill_done` out 1: one-cycle pulse; D-cache fill complete.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, WRITE, FILL_I, FILL_D.
- IDLE selects the next state at each edge, in fixed priority order:
  - `d_wr_req` → WRITE
  - else `d_miss_req` → FILL_D
  - else `i_miss_req` → FILL_I
- On entering a fill state:
  - The block base address (`miss_addr[15:4]`) is latched.
  - `iss_cnt` and `rcv_cnt` are cleared to 0.
- WRITE, one cycle only:
  - Outputs: `mem_en`=1, `mem_wr`=1, `mem_addr`=`d_wr_addr`, `mem_wdata`=`d_wr_data`, `d_wr_ack`=1.
  - Next state: IDLE.
- FILL_x, read issue:
  - While `iss_cnt` < `WORDS`: `mem_en`=1, `mem_wr`=0, `mem_addr`={base, `iss_cnt`, 1'b0}; `iss_cnt` increments every cycle.
  - Once `iss_cnt` reaches `WORDS`, `mem_en`=0.
  - Read issue runs independently of the returns.
- FILL_x, data return:
  - Each `mem_rvalid` produces `x_data_we`=1, `fill_word`=`rcv_cnt`, and `rcv_cnt` increments.
  - When `mem_rvalid` is high and `rcv_cnt`=`WORDS`-1, the following pulse together in the same cycle: `x_tag_we`=1, `x_fill_done`=1. The next state is IDLE.
- `mem_rvalid` is ignored in IDLE and WRITE: no write enables are driven.
- A new request is not re-granted until the state has returned to IDLE, so there is at least one IDLE cycle between grants.
  - The cache miss signal deasserts in that cycle because the tag was written.
- Arithmetic: the block address is formed from the base and word index only; there is no carry.
  - A miss at 0xFFFE fills 0xFFF0–0xFFFE and never touches 0x0000.
- Outputs not named above are driven to 0 in every state.

## Timing
- Reset values:
  - State: IDLE; `iss_cnt`=0, `rcv_cnt`=0; latched base = 0.
  - All strobes and pulses = 0; `busy`=0; `mem_addr`=0; `mem_wdata`=0.
- Reset is asynchronous. Asserting it mid-fill:
  - Immediately forces IDLE and clears all outputs.
  - Leaves partially written words in the cache data array; no tag is written, so the line stays invalid.
- Grant latency: a request high before edge t0 has its state entered at t0. The first `mem_en` is in cycle t0.
- Word k is issued in cycle t0+k.
- With memory read latency L, word k returns in cycle t0+k+L.
  - Done pulses in cycle t0+7+L.
  - IDLE is reached at edge t0+8+L.
- Store: `d_wr_ack` is asserted in cycle t0; the state is back in IDLE at t0+1.
- Requests arriving while `busy`=1 wait and are sampled at the first IDLE edge.
- Simultaneous I and D misses: D fills first. I is granted after the IDLE cycle that follows `d_fill_done`.

## Test plan
- I-miss alone:
  - Stimulus: L=4, `i_miss_addr`=0x1236.
  - Required: reads issued to 0x1230…0x123E in consecutive cycles; 8 `i_data_we` with `fill_word` 0..7; `i_tag_we` and `i_fill_done` both at t0+11; `busy` low at t0+12.
- D-miss with stretched latency:
  - Stimulus: L=6, `d_miss_addr`=0x4000.
  - Required: `d_fill_done` at t0+13; no I-side strobes at any time.
- Simultaneous misses:
  - Stimulus: I and D miss raised in the same cycle.
  - Required: D fill completes, one IDLE cycle, then the I fill; exactly one done pulse per side.
- Store during an I fill:
  - Stimulus: `d_wr_req` raised mid-I-fill (0x2002 ← 0xBEEF).
  - Required: the store waits until the fill ends; single cycle with `mem_wr`=1, `mem_addr`=0x2002, `mem_wdata`=0xBEEF and `d_wr_ack`; both store and D miss pending in IDLE → store is granted first.
- Reset mid-fill:
  - Stimulus: `rst_n` pulled low after 3 returns.
  - Required: all outputs 0 immediately; no tag write; stray `mem_rvalid` afterwards produces no write enables; a fresh miss refills all 8 words.
- Wrap boundary:
  - Stimulus: miss at 0xFFFE.
  - Required: addresses 0xFFF0…0xFFFE; `fill_word` 0..7.
